// File: rtl/sramlike_arbiter.sv
// Two-requester (inst/data) arbiter onto a single sram-like slave, one transaction outstanding.
// Optional macro ARB_RR_EN: round-robin on simultaneous requests instead of fixed data priority.
module sramlike_arbiter (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_req,
   input  logic        i_wr,
   input  logic [1:0]  i_size,
   input  logic [31:0] i_addr,
   input  logic [31:0] i_wdata,
   output logic [31:0] i_rdata,
   output logic        i_addr_ok,
   output logic        i_data_ok,
   input  logic        d_req,
   input  logic        d_wr,
   input  logic [1:0]  d_size,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic [31:0] d_rdata,
   output logic        d_addr_ok,
   output logic        d_data_ok,
   output logic        m_req,
   output logic        m_wr,
   output logic [1:0]  m_size,
   output logic [31:0] m_addr,
   output logic [31:0] m_wdata,
   input  logic [31:0] m_rdata,
   input  logic        m_addr_ok,
   input  logic        m_data_ok
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2
   } state_t;

   state_t r_state;
   state_t w_state_nxt;
   logic   r_owner;        // 1'b1 = data requester owns the bus
   logic   w_owner_nxt;
   logic   w_grant_d;
   logic   w_owner_req;

`ifdef ARB_RR_EN
   logic   r_last;
   logic   w_last_nxt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_last <= 1'b0;
      end else begin
         r_last <= w_last_nxt;
      end
   end

   assign w_grant_d  = (i_req && d_req) ? ~r_last : d_req;
   assign w_last_nxt = ((r_state == IDLE) && (i_req || d_req)) ? w_grant_d : r_last;
`else
   assign w_grant_d  = d_req;
`endif

   assign w_owner_req = r_owner ? d_req : i_req;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_owner <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_owner <= w_owner_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_owner_nxt = r_owner;
      m_req       = 1'b0;
      m_wr        = 1'b0;
      m_size      = 2'd0;
      m_addr      = 32'd0;
      m_wdata     = 32'd0;
      i_addr_ok   = 1'b0;
      d_addr_ok   = 1'b0;
      i_data_ok   = 1'b0;
      d_data_ok   = 1'b0;
      i_rdata     = m_rdata;
      d_rdata     = m_rdata;
      case (r_state)
         IDLE: begin
            if (i_req || d_req) begin
               w_state_nxt = ADDR;
               w_owner_nxt = w_grant_d;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         ADDR: begin
            // A withdrawn request is abandoned without exposing it to the slave.
            if (!w_owner_req) begin
               w_state_nxt = IDLE;
            end else begin
               m_req   = 1'b1;
               m_wr    = r_owner ? d_wr    : i_wr;
               m_size  = r_owner ? d_size  : i_size;
               m_addr  = r_owner ? d_addr  : i_addr;
               m_wdata = r_owner ? d_wdata : i_wdata;
               if (m_addr_ok) begin
                  w_state_nxt = DATA;
                  d_addr_ok   = r_owner;
                  i_addr_ok   = ~r_owner;
               end else begin
                  w_state_nxt = ADDR;
               end
            end
         end
         DATA: begin
            if (m_data_ok) begin
               w_state_nxt = IDLE;
               d_data_ok   = r_owner;
               i_data_ok   = ~r_owner;
            end else begin
               w_state_nxt = DATA;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
      if (rst) begin
         m_req     = 1'b0;
         m_wr      = 1'b0;
         m_size    = 2'd0;
         m_addr    = 32'd0;
         m_wdata   = 32'd0;
         i_addr_ok = 1'b0;
         d_addr_ok = 1'b0;
         i_data_ok = 1'b0;
         d_data_ok = 1'b0;
         i_rdata   = 32'd0;
         d_rdata   = 32'd0;
      end else begin
         i_rdata   = m_rdata;
         d_rdata   = m_rdata;
      end
   end

endmodule

// File: tb/tb_sramlike_arbiter.sv
// Directed self-checking bench for sramlike_arbiter; expectations follow ARB_RR_EN if defined.
module tb_sramlike_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_req, i_wr, d_req, d_wr;
   logic [1:0]  i_size, d_size;
   logic [31:0] i_addr, i_wdata, d_addr, d_wdata;
   logic [31:0] i_rdata, d_rdata;
   logic        i_addr_ok, i_data_ok, d_addr_ok, d_data_ok;
   logic        m_req, m_wr;
   logic [1:0]  m_size;
   logic [31:0] m_addr, m_wdata, m_rdata;
   logic        m_addr_ok, m_data_ok;
   int          n_assert = 0;
   int          n_fail   = 0;
   logic [3:0]  exp_d;

   always #5 clk = ~clk;

   sramlike_arbiter dut (
      .clk(clk), .rst(rst),
      .i_req(i_req), .i_wr(i_wr), .i_size(i_size), .i_addr(i_addr), .i_wdata(i_wdata),
      .i_rdata(i_rdata), .i_addr_ok(i_addr_ok), .i_data_ok(i_data_ok),
      .d_req(d_req), .d_wr(d_wr), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok),
      .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr), .m_wdata(m_wdata),
      .m_rdata(m_rdata), .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // advance to just after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // settle combinational paths before sampling
   task automatic settle();
      #2;
   endtask

   initial begin
      rst = 1'b1;
      i_req = 1'b0; i_wr = 1'b0; i_size = 2'd0; i_addr = 32'd0; i_wdata = 32'd0;
      d_req = 1'b0; d_wr = 1'b0; d_size = 2'd0; d_addr = 32'd0; d_wdata = 32'd0;
      m_rdata = 32'h1234_5678; m_addr_ok = 1'b1; m_data_ok = 1'b1;
      tick(); tick(); settle();
      chk("rst_rdata",   i_rdata, 32'd0);
      chk("rst_d_rdata", d_rdata, 32'd0);
      chk("rst_ok", {28'd0, i_addr_ok, i_data_ok, d_addr_ok, d_data_ok}, 32'd0);
      chk("rst_mreq", {31'd0, m_req}, 32'd0);

      // single inst read
      tick();
      rst = 1'b0; m_addr_ok = 1'b0; m_data_ok = 1'b0; m_rdata = 32'd0;
      i_req = 1'b1; i_addr = 32'hBFC0_0000; i_size = 2'd2;
      settle();
      chk("t1_c1_mreq", {31'd0, m_req}, 32'd0);
      tick(); m_addr_ok = 1'b1; settle();
      chk("t1_c2_mreq",  {31'd0, m_req}, 32'd1);
      chk("t1_c2_maddr", m_addr, 32'hBFC0_0000);
      chk("t1_c2_ok", {28'd0, i_addr_ok, i_data_ok, d_addr_ok, d_data_ok}, 32'h8);
      tick(); i_req = 1'b0; m_addr_ok = 1'b0; settle();
      chk("t1_c3_mreq",  {31'd0, m_req}, 32'd0);
      chk("t1_c3_maddr", m_addr, 32'd0);
      chk("t1_c3_ok", {28'd0, i_addr_ok, i_data_ok, d_addr_ok, d_data_ok}, 32'h0);
      tick(); m_data_ok = 1'b1; m_rdata = 32'h3C1D_0000; settle();
      chk("t1_c4_ok", {28'd0, i_addr_ok, i_data_ok, d_addr_ok, d_data_ok}, 32'h4);
      chk("t1_c4_rdata", i_rdata, 32'h3C1D_0000);
      tick(); settle();
      chk("t1_idle_stray_dok", {28'd0, i_addr_ok, i_data_ok, d_addr_ok, d_data_ok}, 32'h0);
      tick(); m_data_ok = 1'b0;

      // simultaneous requests: data first, then inst
      i_req = 1'b1; i_addr = 32'h0000_1000; i_wr = 1'b0;
      d_req = 1'b1; d_wr = 1'b1; d_addr = 32'h8000_1000; d_wdata = 32'hDEAD_BEEF; d_size = 2'd2;
      settle();
      chk("t2_grant_mreq", {31'd0, m_req}, 32'd0);
      tick(); m_addr_ok = 1'b1; settle();
      chk("t2_d_mwr",    {31'd0, m_wr}, 32'd1);
      chk("t2_d_maddr",  m_addr, 32'h8000_1000);
      chk("t2_d_mwdata", m_wdata, 32'hDEAD_BEEF);
      chk("t2_d_msize",  {30'd0, m_size}, 32'd2);
      chk("t2_d_aok", {28'd0, i_addr_ok, i_data_ok, d_addr_ok, d_data_ok}, 32'h2);
      tick(); d_req = 1'b0; m_addr_ok = 1'b0; settle();
      chk("t2_data_mreq", {31'd0, m_req}, 32'd0);
      tick(); m_data_ok = 1'b1; settle();
      chk("t2_d_dok", {28'd0, i_addr_ok, i_data_ok, d_addr_ok, d_data_ok}, 32'h1);
      tick(); m_data_ok = 1'b0; settle();
      chk("t2_i_grant_mreq", {31'd0, m_req}, 32'd0);
      tick(); m_addr_ok = 1'b1; settle();
      chk("t2_i_maddr", m_addr, 32'h0000_1000);
      chk("t2_i_mwr",   {31'd0, m_wr}, 32'd0);
      chk("t2_i_aok", {28'd0, i_addr_ok, i_data_ok, d_addr_ok, d_data_ok}, 32'h8);
      tick(); i_req = 1'b0; m_addr_ok = 1'b0; m_data_ok = 1'b1; settle();
      chk("t2_i_dok", {28'd0, i_addr_ok, i_data_ok, d_addr_ok, d_data_ok}, 32'h4);
      tick(); m_data_ok = 1'b0;

      // both requesting continuously for four transactions
`ifdef ARB_RR_EN
      exp_d = 4'b0101;
`else
      exp_d = 4'b1111;
`endif
      i_req = 1'b1; d_req = 1'b1; d_wr = 1'b0;
      for (int k = 0; k < 4; k++) begin
         settle();
         chk("t3_idle_mreq", {31'd0, m_req}, 32'd0);
         tick(); m_addr_ok = 1'b1; settle();
         chk("t3_aok", {28'd0, i_addr_ok, i_data_ok, d_addr_ok, d_data_ok},
             exp_d[k] ? 32'h2 : 32'h8);
         tick(); m_addr_ok = 1'b0; m_data_ok = 1'b1; settle();
         chk("t3_dok", {28'd0, i_addr_ok, i_data_ok, d_addr_ok, d_data_ok},
             exp_d[k] ? 32'h1 : 32'h4);
         tick(); m_data_ok = 1'b0;
      end
      i_req = 1'b0; d_req = 1'b0;
      tick();

      // owner withdraws in ADDR before the slave accepts
      d_req = 1'b1; d_addr = 32'h8000_2000;
      tick(); settle();
      chk("t4_addr_mreq", {31'd0, m_req}, 32'd1);
      chk("t4_addr_noaok", {28'd0, i_addr_ok, i_data_ok, d_addr_ok, d_data_ok}, 32'h0);
      tick(); d_req = 1'b0; settle();
      chk("t4_drop_mreq", {31'd0, m_req}, 32'd0);
      tick(); m_addr_ok = 1'b1; m_data_ok = 1'b1; i_req = 1'b1; i_addr = 32'h0000_2000; settle();
      chk("t4_idle_ok", {28'd0, i_addr_ok, i_data_ok, d_addr_ok, d_data_ok}, 32'h0);
      chk("t4_idle_mreq", {31'd0, m_req}, 32'd0);
      tick(); m_data_ok = 1'b0; settle();
      chk("t4_regrant_maddr", m_addr, 32'h0000_2000);
      chk("t4_regrant_aok", {28'd0, i_addr_ok, i_data_ok, d_addr_ok, d_data_ok}, 32'h8);
      tick(); i_req = 1'b0; m_addr_ok = 1'b0; m_data_ok = 1'b1; settle();
      chk("t4_regrant_dok", {28'd0, i_addr_ok, i_data_ok, d_addr_ok, d_data_ok}, 32'h4);
      tick(); m_data_ok = 1'b0;

      // reset while in DATA, then stray data_ok
      d_req = 1'b1; d_addr = 32'h8000_3000;
      tick(); m_addr_ok = 1'b1;
      tick(); d_req = 1'b0; m_addr_ok = 1'b0; rst = 1'b1; m_data_ok = 1'b1; m_rdata = 32'hAAAA_5555; settle();
      chk("t5_rst_ok", {28'd0, i_addr_ok, i_data_ok, d_addr_ok, d_data_ok}, 32'h0);
      chk("t5_rst_rdata", d_rdata, 32'd0);
      tick();
      tick(); rst = 1'b0; m_rdata = 32'd0; settle();
      chk("t5_post_ok", {28'd0, i_addr_ok, i_data_ok, d_addr_ok, d_data_ok}, 32'h0);
      chk("t5_post_m", {m_req, m_wr, m_size, m_addr[27:0]} | m_wdata, 32'd0);
      chk("t5_post_rdata", i_rdata | d_rdata, 32'd0);
      tick(); m_data_ok = 1'b0; d_req = 1'b1; settle();
      chk("t5_idle_mreq", {31'd0, m_req}, 32'd0);
      tick(); m_addr_ok = 1'b1; settle();
      chk("t5_grant_maddr", m_addr, 32'h8000_3000);
      chk("t5_grant_aok", {28'd0, i_addr_ok, i_data_ok, d_addr_ok, d_data_ok}, 32'h2);
      tick(); d_req = 1'b0; m_addr_ok = 1'b0;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
